// File: rtl/crc_stream_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : crc_stream_engine_if
// Brief    : Beat-input and result-output bundle for crc_stream_engine.
// Revision : 1.0 - initial release
// ============================================================================
interface crc_stream_engine_if #(
    parameter int DATA_W = 12,
    parameter int CRC_W  = 12,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic              in_eof;
    logic [DATA_W-1:0] in_data;
    logic [CRC_W-1:0]  exp_crc;
    logic              res_valid;
    logic              res_ready;
    logic [CRC_W-1:0]  res_crc;
    logic              res_err;
    logic [CNT_W-1:0]  res_cnt;
    logic              orphan;

    // master: beat producer and result consumer
    modport master (
        output in_valid, in_sof, in_eof, in_data, exp_crc, res_ready,
        input  in_ready, res_valid, res_crc, res_err, res_cnt, orphan
    );

    modport slave (
        input  in_valid, in_sof, in_eof, in_data, exp_crc, res_ready,
        output in_ready, res_valid, res_crc, res_err, res_cnt, orphan
    );
endinterface
`default_nettype wire

// File: rtl/crc_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : crc_stream_engine
// Brief    : Framed, handshaked MSB-first CRC engine with result hold stage.
//            Define CRC_STREAM_CHECK_EN to compare against exp_crc on EOF.
// Revision : 1.0 - initial release
// ============================================================================
module crc_stream_engine #(
    parameter int               CRC_W   = 12,
    parameter int               DATA_W  = 12,
    parameter logic [CRC_W-1:0] POLY    = 12'h49F,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter int               CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crc_stream_engine_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   res_crc_q, res_crc_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic               res_valid_q, res_valid_d;
    logic               orphan_q, orphan_d;
    logic               res_err_d;

    logic               accept;
    logic               restart;
    logic [CRC_W-1:0]   crc_base;
    logic [CRC_W-1:0]   crc_upd_val;
    logic [CRC_W-1:0]   crc_final;
    logic [CNT_W-1:0]   cnt_next;

    // Serial MSB-first LFSR, unrolled across the whole data word
    function automatic logic [CRC_W-1:0] crc_upd(
        input logic [CRC_W-1:0]  c,
        input logic [DATA_W-1:0] d
    );
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    assign accept      = bus.in_valid && (state_q != HOLD);
    assign restart     = (state_q == IDLE) || bus.in_sof;
    assign crc_base    = restart ? INIT : crc_q;
    assign crc_upd_val = crc_upd(crc_base, bus.in_data);
    assign crc_final   = crc_upd_val ^ XOR_OUT;
    assign cnt_next    = restart ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        res_crc_d   = res_crc_q;
        res_cnt_d   = res_cnt_q;
        res_valid_d = res_valid_q;
        orphan_d    = 1'b0;

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    if ((state_q == IDLE) && !bus.in_sof) begin
                        orphan_d = 1'b1;
                    end else begin
                        crc_d   = crc_upd_val;
                        cnt_d   = cnt_next;
                        state_d = ACC;
                        if (bus.in_eof) begin
                            state_d     = HOLD;
                            res_valid_d = 1'b1;
                            res_crc_d   = crc_final;
                            res_cnt_d   = cnt_next;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            cnt_q       <= '0;
            res_crc_q   <= '0;
            res_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            orphan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            res_crc_q   <= res_crc_d;
            res_cnt_q   <= res_cnt_d;
            res_valid_q <= res_valid_d;
            orphan_q    <= orphan_d;
        end
    end

`ifdef CRC_STREAM_CHECK_EN
    logic res_err_q;

    // Error flag only changes on the beat that also loads the result
    always_comb begin
        res_err_d = res_err_q;
        if (accept && bus.in_eof && !((state_q == IDLE) && !bus.in_sof)) begin
            res_err_d = (crc_final != bus.exp_crc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err_q <= 1'b0;
        end else begin
            res_err_q <= res_err_d;
        end
    end

    assign bus.res_err = res_err_q;
`else
    logic unused_exp_crc;

    assign res_err_d      = 1'b0;
    assign unused_exp_crc = ^{bus.exp_crc, res_err_d};
    assign bus.res_err    = 1'b0;
`endif

    assign bus.in_ready  = (state_q != HOLD);
    assign bus.res_valid = res_valid_q;
    assign bus.res_crc   = res_crc_q;
    assign bus.res_cnt   = res_cnt_q;
    assign bus.orphan    = orphan_q;

endmodule
`default_nettype wire
